// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and helpers for the direct-mapped data cache.
//   dcache_state_t  - controller states (IDLE, FILL, WRITE)
//   calc_*_w        - address field widths derived from the cache geometry
//   addr_*          - address field extraction (word offset, index, tag)
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } dcache_state_t;

    function automatic int calc_off_w(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int calc_idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int calc_tag_w(input int addr_w, input int lines, input int words_per_line);
        return addr_w - 2 - calc_off_w(words_per_line) - calc_idx_w(lines);
    endfunction

    // Generic field extract; callers cast the result to the field width.
    function automatic logic [63:0] addr_field(input logic [63:0] addr, input int lsb, input int width);
        return (addr >> lsb) & ((64'd1 << width) - 64'd1);
    endfunction

    function automatic logic [63:0] addr_offset(input logic [63:0] addr, input int words_per_line);
        return addr_field(addr, 2, calc_off_w(words_per_line));
    endfunction

    function automatic logic [63:0] addr_index(input logic [63:0] addr, input int lines,
                                               input int words_per_line);
        return addr_field(addr, 2 + calc_off_w(words_per_line), calc_idx_w(lines));
    endfunction

    function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int addr_w,
                                             input int lines, input int words_per_line);
        return addr_field(addr, 2 + calc_off_w(words_per_line) + calc_idx_w(lines),
                          calc_tag_w(addr_w, lines, words_per_line));
    endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: tag and data storage for the direct-mapped cache.
//   Synchronous write, combinational read. One tag per line, one word per
//   {index, offset}. Valid bits live in the controller, not here.
//   rd_idx/rd_off   - read address; rd_tag/rd_data combinational outputs
//   tag_we/data_we  - write enables for tag and data word
//   w_idx/w_off     - write address; w_tag/w_data write values
module dcache_array #(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int IDX_W          = 4,
    parameter int OFF_W          = 2,
    parameter int TAG_W          = 26,
    parameter int DATA_W         = 32
) (
    input  logic              clk,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [OFF_W-1:0]  rd_off,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              tag_we,
    input  logic              data_we,
    input  logic [IDX_W-1:0]  w_idx,
    input  logic [OFF_W-1:0]  w_off,
    input  logic [TAG_W-1:0]  w_tag,
    input  logic [DATA_W-1:0] w_data
);

    logic [TAG_W-1:0]  tag_mem_q  [LINES];
    logic [DATA_W-1:0] data_mem_q [LINES*WORDS_PER_LINE];

    always_ff @(posedge clk) begin
        if (tag_we)  tag_mem_q[w_idx]           <= w_tag;
        if (data_we) data_mem_q[{w_idx, w_off}] <= w_data;
    end

    assign rd_tag  = tag_mem_q[rd_idx];
    assign rd_data = data_mem_q[{rd_idx, rd_off}];

endmodule

// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped, write-through, no-write-allocate data cache.
//   Core side : dCacheAddr/ReadEn/WriteEn/WriteData in, dCacheReadData and
//               dCacheStall out (both combinational).
//   Memory    : memReq/memWe/memAddr/memWData registered out; memAck/memRData in,
//               read data valid in the ack cycle.
//
//   state | meaning
//   IDLE  | serve read hits combinationally; launch a refill or a store
//   FILL  | fetch WORDS_PER_LINE words of the missed line, one at a time
//   WRITE | write-through store to memory; update cached word on a hit
module dcache_dm
    import dcache_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] dCacheAddr,
    input  logic              dCacheReadEn,
    input  logic              dCacheWriteEn,
    input  logic [DATA_W-1:0] dCacheWriteData,
    output logic [DATA_W-1:0] dCacheReadData,
    output logic              dCacheStall,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    input  logic              memAck,
    input  logic [DATA_W-1:0] memRData
);

    localparam int OFF_W = calc_off_w(WORDS_PER_LINE);
    localparam int IDX_W = calc_idx_w(LINES);
    localparam int TAG_W = calc_tag_w(ADDR_W, LINES, WORDS_PER_LINE);

    dcache_state_t     state_q, state_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic              whit_q, whit_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [OFF_W-1:0]  req_off;
    logic [IDX_W-1:0]  req_idx, mem_idx;
    logic [TAG_W-1:0]  req_tag, mem_tag, rd_tag;
    logic [DATA_W-1:0] rd_data, w_data;
    logic              tag_we, data_we, hit, read_hit;
    logic [OFF_W-1:0]  w_off;

    assign req_off = OFF_W'(addr_offset(64'(dCacheAddr), WORDS_PER_LINE));
    assign req_idx = IDX_W'(addr_index(64'(dCacheAddr), LINES, WORDS_PER_LINE));
    assign req_tag = TAG_W'(addr_tag(64'(dCacheAddr), ADDR_W, LINES, WORDS_PER_LINE));
    // During FILL/WRITE the registered memory address names the line being touched.
    assign mem_idx = IDX_W'(addr_index(64'(mem_addr_q), LINES, WORDS_PER_LINE));
    assign mem_tag = TAG_W'(addr_tag(64'(mem_addr_q), ADDR_W, LINES, WORDS_PER_LINE));

    assign hit = valid_q[req_idx] && (rd_tag == req_tag);

    dcache_array #(
        .LINES(LINES), .WORDS_PER_LINE(WORDS_PER_LINE), .IDX_W(IDX_W),
        .OFF_W(OFF_W), .TAG_W(TAG_W), .DATA_W(DATA_W)
    ) u_array (
        .clk(clk), .rd_idx(req_idx), .rd_off(req_off), .rd_tag(rd_tag), .rd_data(rd_data),
        .tag_we(tag_we), .data_we(data_we), .w_idx(mem_idx), .w_off(w_off),
        .w_tag(mem_tag), .w_data(w_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q;
        whit_d      = whit_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        tag_we      = 1'b0;
        data_we     = 1'b0;
        w_off       = cnt_q;
        w_data      = memRData;
        dCacheStall = 1'b0;
        read_hit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (dCacheWriteEn) begin
                    dCacheStall = 1'b1;
                    state_d     = WRITE;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {dCacheAddr[ADDR_W-1:2], 2'b00};
                    mem_wdata_d = dCacheWriteData;
                    // Hit status is captured now; the line cannot change before the ack.
                    whit_d      = hit;
                end else if (dCacheReadEn) begin
                    if (hit) begin
                        read_hit = 1'b1;
                    end else begin
                        dCacheStall = 1'b1;
                        state_d     = FILL;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = {dCacheAddr[ADDR_W-1:2+OFF_W], {(2+OFF_W){1'b0}}};
                    end
                end
            end
            FILL: begin
                dCacheStall = 1'b1;
                if (memAck) begin
                    data_we = 1'b1;
                    if (cnt_q == {OFF_W{1'b1}}) begin
                        tag_we           = 1'b1;
                        valid_d[mem_idx] = 1'b1;
                        mem_req_d        = 1'b0;
                        cnt_d            = '0;
                        state_d          = IDLE;
                    end else begin
                        cnt_d      = cnt_q + OFF_W'(1);
                        mem_addr_d = mem_addr_q + ADDR_W'(4);
                    end
                end
            end
            WRITE: begin
                dCacheStall = !memAck;
                w_off       = OFF_W'(addr_offset(64'(mem_addr_q), WORDS_PER_LINE));
                w_data      = mem_wdata_q;
                if (memAck) begin
                    data_we   = whit_q;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            valid_q     <= '0;
            whit_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            whit_q      <= whit_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign dCacheReadData = read_hit ? rd_data : '0;
    assign memReq         = mem_req_q;
    assign memWe          = mem_we_q;
    assign memAddr        = mem_addr_q;
    assign memWData       = mem_wdata_q;

endmodule

// File: tb/tb_dcache_dm.sv
module tb_dcache_dm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dCacheAddr = '0;
    logic        dCacheReadEn = 1'b0;
    logic        dCacheWriteEn = 1'b0;
    logic [31:0] dCacheWriteData = '0;
    logic [31:0] dCacheReadData;
    logic        dCacheStall;
    logic        memReq, memWe, memAck;
    logic [31:0] memAddr, memWData, memRData;

    int errors = 0;
    int checks = 0;

    // Memory model: data = address, ack after mem_delay wait cycles.
    int          mem_delay = 0;
    int          wcnt = 0;
    int          wr_count = 0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;

    logic [31:0] got_addr [8];
    int          n_acks;

    always #5 clk = ~clk;

    dcache_dm dut (
        .clk(clk), .rst(rst),
        .dCacheAddr(dCacheAddr), .dCacheReadEn(dCacheReadEn), .dCacheWriteEn(dCacheWriteEn),
        .dCacheWriteData(dCacheWriteData), .dCacheReadData(dCacheReadData),
        .dCacheStall(dCacheStall),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
        .memAck(memAck), .memRData(memRData)
    );

    assign memAck   = memReq && (wcnt >= mem_delay);
    assign memRData = memAddr;

    always @(posedge clk) begin
        if (rst || !memReq || memAck) wcnt <= 0;
        else                          wcnt <= wcnt + 1;
        if (memReq && memAck && memWe) begin
            wr_count <= wr_count + 1;
            wr_addr  <= memAddr;
            wr_data  <= memWData;
        end
    end

    task automatic do_read(input logic [31:0] a, output logic [31:0] data,
                           output int stalls, output int unstable);
        logic        p_req, p_ack, p_we, done;
        logic [31:0] p_addr;
        p_req = 0; p_ack = 0; p_we = 0; p_addr = '0; done = 0;
        stalls = 0; unstable = 0; n_acks = 0; data = '0;
        dCacheAddr = a; dCacheReadEn = 1'b1; dCacheWriteEn = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (memReq && memAck && !memWe) begin
                if (n_acks < 8) got_addr[n_acks] = memAddr;
                n_acks++;
            end
            if (p_req && !p_ack && (memReq !== 1'b1 || memAddr !== p_addr || memWe !== p_we))
                unstable++;
            p_req = memReq; p_ack = memAck; p_we = memWe; p_addr = memAddr;
            if (!dCacheStall) begin
                data = dCacheReadData;
                done = 1;
                break;
            end
            stalls++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL read_timeout addr=%h: stall never dropped", a);
        end
        @(posedge clk); #1;
        dCacheReadEn = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            output int stalls, output int nwrites);
        int  start;
        logic done;
        start = wr_count; stalls = 0; done = 0;
        dCacheAddr = a; dCacheWriteData = d; dCacheWriteEn = 1'b1; dCacheReadEn = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!dCacheStall) begin
                done = 1;
                break;
            end
            stalls++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL write_timeout addr=%h: stall never dropped", a);
        end
        @(posedge clk); #1;
        dCacheWriteEn = 1'b0;
        nwrites = wr_count - start;
    endtask

    task automatic check_fill(input string name, input logic [31:0] base);
        checks++;
        if (n_acks !== 4) begin
            errors++;
            $display("FAIL %s_acks got=%0d exp=4", name, n_acks);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got_addr[k] !== base + 32'(4 * k)) begin
                errors++;
                $display("FAIL %s_addr%0d got=%h exp=%h", name, k, got_addr[k], base + 32'(4 * k));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; dCacheReadEn = 0; dCacheWriteEn = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({memReq, memWe, memAddr, memWData} !== 66'd0) begin
            errors++;
            $display("FAIL reset_mem got req=%b we=%b addr=%h wdata=%h exp all 0",
                     memReq, memWe, memAddr, memWData);
        end
        checks++;
        if (dCacheStall !== 1'b0 || dCacheReadData !== 32'd0) begin
            errors++;
            $display("FAIL reset_core got stall=%b rdata=%h exp 0/0", dCacheStall, dCacheReadData);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_read_miss_zero_wait();
        logic [31:0] d; int st, un;
        mem_delay = 0;
        do_read(32'h40, d, st, un);
        checks++;
        if (st !== 5) begin errors++; $display("FAIL miss0_stall got=%0d exp=5", st); end
        check_fill("miss0", 32'h40);
        checks++;
        if (d !== 32'h40) begin errors++; $display("FAIL miss0_data got=%h exp=00000040", d); end
        checks++;
        if (memReq !== 1'b0) begin errors++; $display("FAIL miss0_req_drop got=%b exp=0", memReq); end
    endtask

    task automatic test_read_miss_wait();
        logic [31:0] d; int st, un;
        test_reset();
        mem_delay = 3;
        do_read(32'h40, d, st, un);
        checks++;
        if (st !== 17) begin errors++; $display("FAIL miss3_stall got=%0d exp=17", st); end
        checks++;
        if (un !== 0) begin errors++; $display("FAIL miss3_stable got=%0d changes exp=0", un); end
        check_fill("miss3", 32'h40);
        checks++;
        if (d !== 32'h40) begin errors++; $display("FAIL miss3_data got=%h exp=00000040", d); end
        mem_delay = 0;
    endtask

    task automatic test_hit_and_write_hit();
        logic [31:0] d; int st, un, nw;
        do_read(32'h4C, d, st, un);
        checks++;
        if (st !== 0 || d !== 32'h4C) begin
            errors++; $display("FAIL hit_4c got stall=%0d data=%h exp 0/0000004c", st, d);
        end
        do_write(32'h44, 32'hDEADBEEF, st, nw);
        checks++;
        if (st !== 1 || nw !== 1) begin
            errors++; $display("FAIL whit_cost got stall=%0d writes=%0d exp 1/1", st, nw);
        end
        checks++;
        if (wr_addr !== 32'h44 || wr_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL whit_mem got addr=%h data=%h exp 00000044/deadbeef", wr_addr, wr_data);
        end
        do_read(32'h44, d, st, un);
        checks++;
        if (st !== 0 || d !== 32'hDEADBEEF) begin
            errors++; $display("FAIL whit_read got stall=%0d data=%h exp 0/deadbeef", st, d);
        end
    endtask

    task automatic test_write_miss();
        logic [31:0] d; int st, un, nw;
        do_write(32'h200, 32'h1234, st, nw);
        checks++;
        if (st !== 1 || nw !== 1 || wr_addr !== 32'h200 || wr_data !== 32'h1234) begin
            errors++;
            $display("FAIL wmiss got stall=%0d writes=%0d addr=%h data=%h exp 1/1/00000200/00001234",
                     st, nw, wr_addr, wr_data);
        end
        do_read(32'h200, d, st, un);
        checks++;
        if (st !== 5 || d !== 32'h200) begin
            errors++; $display("FAIL wmiss_read got stall=%0d data=%h exp 5/00000200", st, d);
        end
        check_fill("wmiss", 32'h200);
    endtask

    task automatic test_conflict();
        logic [31:0] d; int st, un;
        do_read(32'h1040, d, st, un);
        checks++;
        if (st !== 5 || d !== 32'h1040) begin
            errors++; $display("FAIL conflict_1040 got stall=%0d data=%h exp 5/00001040", st, d);
        end
        check_fill("conflict", 32'h1040);
        do_read(32'h40, d, st, un);
        checks++;
        if (st !== 5 || d !== 32'h40) begin
            errors++; $display("FAIL conflict_40 got stall=%0d data=%h exp 5/00000040", st, d);
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] d; int st, un, acks; logic seen;
        test_reset();
        mem_delay = 0; acks = 0; seen = 0;
        dCacheAddr = 32'h40; dCacheReadEn = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (memReq && memAck) acks++;
            if (acks == 2) begin
                rst  = 1'b1;
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL midfill_acks got=%0d exp=2", acks); end
        @(posedge clk); #1;
        checks++;
        if (memReq !== 1'b0) begin errors++; $display("FAIL midfill_req got=%b exp=0", memReq); end
        rst = 1'b0; dCacheReadEn = 1'b0;
        @(posedge clk); #1;
        do_read(32'h40, d, st, un);
        checks++;
        if (st !== 5 || d !== 32'h40) begin
            errors++; $display("FAIL midfill_refill got stall=%0d data=%h exp 5/00000040", st, d);
        end
        check_fill("midfill", 32'h40);
    endtask

    task automatic test_idle();
        @(negedge clk);
        checks++;
        if (dCacheStall !== 1'b0 || memReq !== 1'b0 || dCacheReadData !== 32'd0) begin
            errors++;
            $display("FAIL idle got stall=%b req=%b rdata=%h exp 0/0/0", dCacheStall, memReq, dCacheReadData);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_read_miss_zero_wait();
        test_read_miss_wait();
        test_hit_and_write_hit();
        test_write_miss();
        test_conflict();
        test_idle();
        test_reset_mid_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
